wptr_full: RTL and testbench

- Write-side pointer and full-flag stage of the async FIFO, in the write clock domain, directly upstream of the dual-port FIFO memory.
- Generates the memory write address and write enable; the enable is already qualified by the full flag.
- Produces the Gray-coded write pointer for the read domain.
- Synchronizes the read domain's Gray pointer into wclk and derives full, occupancy and optional almost-full.

---
 rtl/wptr_full_pkg.sv | 22 ++
 rtl/wptr_full_sync_r2w.sv | 26 ++
 rtl/wptr_full.sv | 81 ++++++++
 tb/tb_wptr_full.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/wptr_full_pkg.sv
// Shared async-FIFO pointer definitions: default address width and Gray/binary
// conversion helpers used by both the write-side and read-side pointer blocks.
package wptr_full_pkg;

  localparam int ADDRSIZE_DFLT = 5;
  localparam int PTRSIZE       = ADDRSIZE_DFLT + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs convert unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_sync_r2w.sv
// Two-flop synchronizer carrying a Gray pointer into the wclk domain; the same
// block serves as the read-side write-pointer synchronizer.
module wptr_full_sync_r2w
  import wptr_full_pkg::*;
#(
  parameter int WIDTH = PTRSIZE
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [WIDTH-1:0] rptr,
  output logic [WIDTH-1:0] wq2_rptr
);

  logic [WIDTH-1:0] wq1_rptr;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

endmodule

// File: rtl/wptr_full.sv
// Async FIFO write-side pointer, Gray pointer export and full/occupancy flags.
// Optional almost-full flag is built only when WPTR_FULL_ALMOST_FULL_EN is defined.
module wptr_full
  import wptr_full_pkg::*;
#(
  parameter int ADDRSIZE     = ADDRSIZE_DFLT,
  parameter int AFULL_THRESH = 2**ADDRSIZE - 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic                wclken,
  output logic                wfull,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   wcount,
  output logic                walmost_full
);

  localparam int PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] wq2_rbin;
  logic              wfullnext;

  wptr_full_sync_r2w #(
    .WIDTH (PW)
  ) u_sync_r2w (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .rptr     (rptr),
    .wq2_rptr (wq2_rptr)
  );

  assign wclken    = winc & ~wfull;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wclken};
  assign wgraynext = PW'(bin2gray(32'(wbinnext)));
  assign wq2_rbin  = PW'(gray2bin(32'(wq2_rptr)));
  assign waddr     = wbin[ADDRSIZE-1:0];
  assign wcount    = wbin - wq2_rbin;

  // Full when the next write pointer laps the synchronized read pointer once.
  assign wfullnext = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                     wq2_rptr[ADDRSIZE-2:0]});

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin  <= '0;
      wptr  <= '0;
      wfull <= 1'b0;
    end else begin
      wbin  <= wbinnext;
      wptr  <= wgraynext;
      wfull <= wfullnext;
    end
  end

`ifdef WPTR_FULL_ALMOST_FULL_EN
  logic [ADDRSIZE:0] wnextcount;

  assign wnextcount = wbinnext - wq2_rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= (wnextcount >= PW'(AFULL_THRESH));
    end
  end
`else
  logic [31:0] afull_thresh_unused;

  assign afull_thresh_unused = AFULL_THRESH;
  assign walmost_full        = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Directed self-checking bench for wptr_full at ADDRSIZE=5 (depth 32).
module tb_wptr_full;

  localparam int AW = 5;
  localparam int PW = AW + 1;
`ifdef WPTR_FULL_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          winc;
  logic [PW-1:0] rptr;
  logic          wclken;
  logic          wfull;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] wcount;
  logic          walmost_full;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic          winc;
    logic [PW-1:0] rptr;
    logic [AW-1:0] expWaddr;
    logic [PW-1:0] expWptr;
    logic          expWfull;
    logic [PW-1:0] expWcount;
    logic          expWclken;
    logic          expAlmost;
  } vec_t;

  vec_t vecs[38];

  wptr_full #(
    .ADDRSIZE     (AW),
    .AFULL_THRESH (28)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr         (rptr),
    .wclken       (wclken),
    .wfull        (wfull),
    .waddr        (waddr),
    .wptr         (wptr),
    .wcount       (wcount),
    .walmost_full (walmost_full)
  );

  always #5 wclk = ~wclk;

  function automatic logic [PW-1:0] gray6(input int v);
    logic [PW-1:0] b;
    b = PW'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic applyStimulus(input logic incIn, input logic [PW-1:0] rptrIn);
    winc = incIn;
    rptr = rptrIn;
    @(posedge wclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkAll(input string tag, input int eAddr, input int ePtr, input int eFull,
                          input int eCount, input int eClken, input int eAlmost);
    checkOutput({tag, " waddr"}, int'(waddr), eAddr);
    checkOutput({tag, " wptr"}, int'(wptr), ePtr);
    checkOutput({tag, " wfull"}, int'(wfull), eFull);
    checkOutput({tag, " wcount"}, int'(wcount), eCount);
    checkOutput({tag, " wclken"}, int'(wclken), eClken);
    checkOutput({tag, " walmost_full"}, int'(walmost_full), eAlmost);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulseReset();
    winc   = 1'b0;
    rptr   = '0;
    #1 wrst_n = 1'b0;
    #1 wrst_n = 1'b1;
  endtask

  initial begin
    logic [PW-1:0] prevPtr;
    int            n;

    // Fill to full, hold while full, then release from a single read.
    for (int i = 1; i <= 34; i++) begin
      n = (i > 32) ? 32 : i;
      vecs[i-1] = '{1'b1, 6'd0, AW'(n % 32), gray6(n), (i >= 32), PW'(n),
                    (i < 32), AF_EN && (n >= 28)};
    end
    vecs[34] = '{1'b0, 6'b000001, 5'd0, 6'b110000, 1'b1, 6'd32, 1'b0, AF_EN};
    vecs[35] = '{1'b0, 6'b000001, 5'd0, 6'b110000, 1'b1, 6'd31, 1'b0, AF_EN};
    vecs[36] = '{1'b1, 6'b000001, 5'd0, 6'b110000, 1'b0, 6'd31, 1'b1, AF_EN};
    vecs[37] = '{1'b1, 6'b000001, 5'd1, 6'b110001, 1'b1, 6'd32, 1'b0, AF_EN};

    wrst_n = 1'b0;
    winc   = 1'b1;
    rptr   = '0;

    // Reset held with writes requested.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, '0);
    checkAll("reset", 0, 0, 0, 0, 1, 0);
    wrst_n = 1'b1;
    applyStimulus(1'b1, '0);
    checkOutput("post-reset waddr", int'(waddr), 1);
    checkOutput("post-reset wptr", int'(wptr), 1);

    pulseReset();
    for (int i = 0; i < 38; i++) begin
      applyStimulus(vecs[i].winc, vecs[i].rptr);
      checkAll($sformatf("vec%0d", i), int'(vecs[i].expWaddr), int'(vecs[i].expWptr),
               int'(vecs[i].expWfull), int'(vecs[i].expWcount), int'(vecs[i].expWclken),
               int'(vecs[i].expAlmost));
    end

    // Wrap: read side trails by 4 words, pointer passes 63 -> 0.
    pulseReset();
    prevPtr = '0;
    for (int j = 1; j <= 74; j++) begin
      applyStimulus(1'b1, gray6((j >= 3) ? j - 3 : 0));
      checkOutput($sformatf("wrap%0d waddr", j), int'(waddr), j % 32);
      checkOutput($sformatf("wrap%0d wptr", j), int'(wptr), int'(gray6(j % 64)));
      checkOutput($sformatf("wrap%0d wfull", j), int'(wfull), 0);
      checkOutput($sformatf("wrap%0d wcount", j), int'(wcount), (j < 4) ? j : 4);
      checkOutput($sformatf("wrap%0d onebit", j), $countones(wptr ^ prevPtr), 1);
      prevPtr = wptr;
    end

    // Async reset in the middle of a fill, then refill to full.
    pulseReset();
    for (int j = 0; j < 17; j++) applyStimulus(1'b1, '0);
    checkOutput("midfill wcount", int'(wcount), 17);
    #2 wrst_n = 1'b0;
    #1;
    checkAll("async-reset", 0, 0, 0, 0, 1, 0);
    wrst_n = 1'b1;
    for (int j = 0; j < 31; j++) applyStimulus(1'b1, '0);
    checkOutput("refill31 wfull", int'(wfull), 0);
    applyStimulus(1'b1, '0);
    checkOutput("refill32 wfull", int'(wfull), 1);
    checkOutput("refill32 wcount", int'(wcount), 32);

    // Almost-full rise at 28 words and fall three edges after a read.
    pulseReset();
    for (int j = 0; j < 27; j++) applyStimulus(1'b1, '0);
    checkOutput("af27 walmost_full", int'(walmost_full), 0);
    applyStimulus(1'b1, '0);
    checkOutput("af28 walmost_full", int'(walmost_full), int'(AF_EN));
    applyStimulus(1'b0, 6'b000001);
    checkOutput("afrel1 walmost_full", int'(walmost_full), int'(AF_EN));
    applyStimulus(1'b0, 6'b000001);
    checkOutput("afrel2 walmost_full", int'(walmost_full), int'(AF_EN));
    checkOutput("afrel2 wcount", int'(wcount), 27);
    applyStimulus(1'b0, 6'b000001);
    checkOutput("afrel3 walmost_full", int'(walmost_full), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
